// File: rtl/div_unit_pkg.sv
// Shared CPU definitions used by the divider and its neighbours.
//   div_state_e  : divider FSM state encoding (DIV_IDLE, DIV_RUN, DIV_DONE)
//   HILO_WE_BOTH : HI/LO write-enable value that writes both halves
package cpu_defs;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration, purely combinational.
//   rem_i, quot_i : partial remainder and quotient/dividend shift register
//   divisor_i     : magnitude of the divisor
//   rem_o, quot_o : values after one shift-and-conditional-subtract
// Isolated so a higher-radix step can be dropped in without touching the FSM.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  always_comb begin
    rem_sh = {rem_i, quot_i[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, divisor_i});
    // When ge is set the difference is below the divisor, so the low WIDTH
    // bits of the shifted remainder are enough for the subtraction.
    diff   = rem_sh[WIDTH-1:0] - divisor_i;
    rem_o  = ge ? diff : rem_sh[WIDTH-1:0];
    quot_o = {quot_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit feeding the HI/LO register.
//   clk, rst  : clock, synchronous active-high reset
//   start_i   : launch a division (only honoured in IDLE)
//   signed_i  : 1 = DIV, 0 = DIVU, captured with start_i
//   cancel_i  : abort the in-flight operation
//   a_i, b_i  : dividend / divisor, captured with start_i
//   busy_o    : unit is not idle
//   valid_o   : one-cycle completion pulse
//   we_o      : {hi_we, lo_we}, both set with valid_o
//   hi_o      : remainder, lo_o : quotient (held until the next completion)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// DIV_IDLE | waiting for start_i
// DIV_RUN  | one restoring iteration per cycle, WIDTH cycles
// DIV_DONE | result presented for one cycle, HI/LO written
module div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [1:0]       we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_q_q, neg_q_d;   // negate quotient at the end
  logic             neg_r_q, neg_r_d;   // negate remainder at the end
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] step_rem, step_quot;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] fin_rem, fin_quot;
  logic             do_done;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  always_comb begin
    abs_a    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    abs_b    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    // Sign fix-up; the -2^31 / -1 case wraps back to 0x80000000 naturally.
    fin_quot = neg_q_q ? -quot_q : quot_q;
    fin_rem  = neg_r_q ? -rem_q : rem_q;
    // cancel_i suppresses the completion in the same cycle it arrives.
    do_done  = (state_q == DIV_DONE) && !cancel_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (start_i && !cancel_i) begin
          dvsr_d = abs_b;
          cnt_d  = '0;
          if (b_i == '0) begin
            // Divide by zero: remainder = dividend, quotient = all ones,
            // with no sign fix-up applied.
            rem_d   = a_i;
            quot_d  = '1;
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = DIV_DONE;
          end else begin
            rem_d   = '0;
            quot_d  = abs_a;
            neg_q_d = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r_d = signed_i && a_i[WIDTH-1];
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        if (cancel_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
        if (do_done) begin
          hi_d = fin_rem;
          lo_d = fin_quot;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // The result is visible during DONE itself, then held from the registers.
  assign busy_o  = (state_q != DIV_IDLE);
  assign valid_o = do_done;
  assign we_o    = do_done ? HILO_WE_BOTH : 2'b00;
  assign hi_o    = do_done ? fin_rem  : hi_q;
  assign lo_o    = do_done ? fin_quot : lo_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, cancel_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, valid_o;
  logic [1:0]  we_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb_q[$];

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .cancel_i (cancel_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .we_o     (we_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {rem, quot} from plain magnitude arithmetic.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    ua = a[31] ? (32'd0 - a) : a;
    ub = b[31] ? (32'd0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Scoreboard: every completion pops one expected result.
  always @(negedge clk) begin
    if (valid_o) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check_eq("hi", {32'd0, hi_o}, {32'd0, e[63:32]});
        check_eq("lo", {32'd0, lo_o}, {32'd0, e[31:0]});
        check_eq("we", {62'd0, we_o}, 64'd3);
      end
    end else if (we_o != 2'b00) begin
      check_eq("we_without_valid", {62'd0, we_o}, 64'd0);
    end
  end

  // Launch one op, expect completion at exp_lat cycles after acceptance and
  // busy for exactly exp_lat cycles. coll_k > 0 pulses a stray start then.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat, input int coll_k);
    int seen;
    int bcnt;
    seen = 0;
    bcnt = 0;
    sb_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
    for (int k = 1; k <= exp_lat + 3; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (coll_k > 0 && k == coll_k) begin
        start_i = 1'b1; signed_i = 1'b0; a_i = 32'd55; b_i = 32'd1;
      end
      if (coll_k > 0 && k == coll_k + 1) start_i = 1'b0;
      if (busy_o) bcnt++;
      if (valid_o && seen == 0) seen = k;
    end
    check_eq({tag, "_latency"}, 64'(seen), 64'(exp_lat));
    check_eq({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] ra, rb, prev_hi, prev_lo;
    logic        rs;
    int          lat;

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
    a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  {63'd0, busy_o}, 64'd0);
    check_eq("rst_valid", {63'd0, valid_o}, 64'd0);
    check_eq("rst_hi",    {32'd0, hi_o}, 64'd0);
    check_eq("rst_lo",    {32'd0, lo_o}, 64'd0);
    rst = 1'b0;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, 0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33, 0);
    run_op("divu_by0", 1'b0, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1, 0);
    run_op("div_by0", 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1, 0);

    // Cancel mid-run: no completion, outputs keep the previous result.
    prev_hi = 32'hFFFF_FF00;
    prev_lo = 32'hFFFF_FFFF;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (k == 10) cancel_i = 1'b1;
      if (k == 11) begin
        cancel_i = 1'b0;
        check_eq("cancel_busy", {63'd0, busy_o}, 64'd0);
      end
    end
    check_eq("cancel_hold_hi", {32'd0, hi_o}, {32'd0, prev_hi});
    check_eq("cancel_hold_lo", {32'd0, lo_o}, {32'd0, prev_lo});
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33, 0);

    // Reset mid-operation.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        rst = 1'b0;
        check_eq("midrst_busy",  {63'd0, busy_o}, 64'd0);
        check_eq("midrst_valid", {63'd0, valid_o}, 64'd0);
        check_eq("midrst_we",    {62'd0, we_o}, 64'd0);
        check_eq("midrst_hi",    {32'd0, hi_o}, 64'd0);
        check_eq("midrst_lo",    {32'd0, lo_o}, 64'd0);
      end
    end

    // Stray start during RUN must not disturb the running op.
    run_op("collide", 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 20);

    // start with cancel in IDLE: nothing accepted.
    @(negedge clk);
    start_i = 1'b1; cancel_i = 1'b1; a_i = 32'd8; b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    check_eq("start_cancel_busy", {63'd0, busy_o}, 64'd0);
    repeat (40) @(negedge clk);

    // Random mix checked against the magnitude model.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i == 4) rb = 32'd0;
      rs = 1'($urandom_range(0, 1));
      if (i % 2 == 1) ra = -ra;
      m = model(rs, ra, rb);
      lat = (rb == 32'd0) ? 1 : 33;
      run_op("rand", rs, ra, rb, m[63:32], m[31:0], lat, 0);
    end

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the MIPS execute stage.
- Implements DIV and DIVU. Sits directly upstream of the HI/LO register.
- Remainder is written to HI and quotient to LO, via a 2-bit write-enable that pulses on completion.
- Radix-2 restoring algorithm, one quotient bit per cycle. The pipeline stalls on busy_o.

Parameters:
- WIDTH, 32, operand/result width in bits. The iteration count equals WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  request a division; sampled only in IDLE
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start_i
- cancel_i  in  1  flush/exception abort; discards the in-flight operation
- a_i  in  WIDTH  dividend; captured with start_i
- b_i  in  WIDTH  divisor; captured with start_i
- busy_o  out  1  high whenever state is not IDLE
- valid_o  out  1  one-cycle completion pulse
- we_o  out  2  {hi_we, lo_we}; equals 2'b11 when valid_o=1, else 2'b00
- hi_o  out  WIDTH  remainder
- lo_o  out  WIDTH  quotient

Behaviour:
- Reset, in any state: state=IDLE, busy_o=0, valid_o=0, we_o=0, hi_o=0, lo_o=0, and all internal registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 and cancel_i=0 captures the operands.
  - If the divisor is nonzero, go to RUN with the iteration counter set to 0.
  - If the divisor is zero, go to DONE directly.
- RUN:
  - Each cycle, shift the {rem, quot} pair left by 1.
  - If rem >= |divisor|, subtract and set the quotient LSB.
  - After iteration WIDTH-1 (counter wraps), go to DONE.
- DONE:
  - For exactly one cycle: valid_o=1, we_o=2'b11, hi_o/lo_o hold the final result.
  - Then return to IDLE.
- Output hold: hi_o and lo_o hold their value after DONE until the next DONE or reset. They are updated only in the DONE cycle.
- Latency:
  - start_i accepted at cycle N: RUN occupies N+1..N+WIDTH, DONE is at N+WIDTH+1. With WIDTH=32, valid_o is high at N+33.
  - busy_o is high from N+1 through N+WIDTH+1 inclusive.
  - A new start_i can be accepted at N+WIDTH+2.
- Signed handling (signed_i=1):
  - Operate on absolute values.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
- Overflow case: -2^31 / -1 yields quotient 0x80000000 and remainder 0. No trap; this result falls out of 32-bit wrap arithmetic.
- Divide by zero (either signedness): quotient=all-ones, remainder=a_i. valid_o is high at N+1. busy_o is high only at N+1.
- start_i while busy_o=1 is ignored. Operands are not recaptured.
- cancel_i=1 in RUN or DONE:
  - Next state is IDLE.
  - In DONE, valid_o and we_o are suppressed combinationally.
  - hi_o and lo_o are not updated.
- cancel_i and start_i together in IDLE: cancel wins and nothing is captured.
- rst together with any other input: reset wins.

Decomposition:
- Shared package (cpu_defs) holds:
  - State encoding constants DIV_IDLE, DIV_RUN, DIV_DONE (2-bit).
  - HILO write-enable constant HILO_WE_BOTH = 2'b11.
- One sub-module: div_step.
  - Purely combinational single iteration: inputs rem, quot, divisor; outputs next rem and next quot.
  - Kept separate so a radix-4 variant can replace it later.

Test Plan:
- Unsigned: start, DIVU a=100 b=7 -> valid_o at start+33, lo_o=14, hi_o=2, we_o=2'b11 for one cycle, busy_o high 33 cycles.
- Signed: DIV a=-7 (0xFFFFFFF9) b=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). Also DIV a=7 b=-2 -> lo_o=-3, hi_o=1.
- Boundary: DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. DIVU 0xFFFFFFFF / 1 -> lo_o=0xFFFFFFFF, hi_o=0.
- Divide by zero: DIVU a=0x1234 b=0 -> valid_o at start+1, lo_o=0xFFFFFFFF, hi_o=0x1234.
- Cancel:
  - Start DIVU 100/7, cancel_i at start+10 -> busy_o low at start+11, no valid_o pulse, hi_o/lo_o keep their prior values.
  - Then start 9/3 -> lo_o=3, hi_o=0.
- Reset mid-operation plus start collision:
  - rst at start+5 -> all outputs 0 the next cycle.
  - start_i pulsed at start+20 of a running op is ignored; that op's result is unchanged.
  - start_i with cancel_i in IDLE -> busy_o stays 0.
